block_sequencer: RTL and testbench

//  Controller that sequences the 4-operand processing block. Captures operands

---
 rtl/block_seq_pkg.sv | 18 +
 rtl/seq_timer.sv | 28 ++
 rtl/block_sequencer.sv | 167 ++++++++++++++++
 tb/tb_block_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/block_seq_pkg.sv
// Shared types and constants for the block sequencer: FSM state encoding and
// error-cause codes reported on err_cause.
package block_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam int NUM_SLOTS = 4;

    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_INCOMPLETE = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT    = 2'b10;

endpackage

// File: rtl/seq_timer.sv
// Saturating RUN-cycle counter; o_expired is high on the last allowed cycle
// (count == TIMEOUT-1) and stays high until cleared.
module seq_timer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/block_sequencer.sv
// Sequencer for the 4-operand processing block: operand capture, one launch per
// go rising edge, result capture with a timeout, sticky done/err status.
module block_sequencer
    import block_seq_pkg::*;
#(
    parameter int W       = 4,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   ld_stb,
    input  logic [W-1:0] ld_data,
    input  logic         go,
    input  logic         clr,
    output logic [W-1:0] op1,
    output logic [W-1:0] op2,
    output logic [W-1:0] op3,
    output logic [W-1:0] op4,
    output logic         bk_go,
    input  logic         bk_rdy,
    input  logic [W-1:0] bk_out,
    output logic [W-1:0] result,
    output logic [3:0]   loaded,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [1:0]   err_cause,
    output state_t       dbg_state
);

    // Handshake with the block: bk_go is a single-cycle launch pulse; bk_rdy is
    // a level that is accepted only while in RUN, and the first accepted cycle ends it.
    state_t         r_state;
    state_t         w_next;
    logic           r_go_q;
    logic [W-1:0]   r_op [NUM_SLOTS];
    logic [W-1:0]   r_result;
    logic [3:0]     r_loaded;
    logic           r_done;
    logic           r_err;
    logic [1:0]     r_cause;
    logic           w_go_edge;
    logic           w_full;
    logic           w_expired;
    logic           w_launch;
    logic           w_refuse;
    logic           w_complete;
    logic           w_timeout;

    assign w_go_edge  = go & ~r_go_q;
    assign w_full     = (r_loaded == 4'hF);
    assign w_launch   = (r_state == IDLE) && w_go_edge && w_full;
    assign w_refuse   = (r_state == IDLE) && w_go_edge && !w_full;
    assign w_complete = (r_state == RUN) && bk_rdy;
    assign w_timeout  = (r_state == RUN) && !bk_rdy && w_expired;

    seq_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (r_state == ARM),
        .i_en      (r_state == RUN),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_launch) begin
                    w_next = ARM;
                end else if (w_refuse) begin
                    w_next = ERR;
                end
            end
            ARM: w_next = RUN;
            RUN: begin
                if (bk_rdy) begin
                    w_next = IDLE;
                end else if (w_expired) begin
                    w_next = ERR;
                end
            end
            ERR: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        bk_go = 1'b0;
        case (r_state)
            ARM: begin
                busy  = 1'b1;
                bk_go = 1'b1;
            end
            RUN: busy = 1'b1;
            default: ;
        endcase
    end

    // Error flags are registered on the transition into ERR so err rises in
    // the same cycle busy falls; later assignments give set events priority over clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_go_q   <= 1'b0;
            r_op     <= '{default: '0};
            r_result <= '0;
            r_loaded <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_cause  <= ERR_NONE;
        end else begin
            r_go_q <= go;
            if (r_state == IDLE) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (ld_stb[i]) begin
                        r_op[i] <= ld_data;
                    end
                end
                r_loaded <= r_loaded | ld_stb;
            end
            if (clr || w_launch) begin
                r_done  <= 1'b0;
                r_err   <= 1'b0;
                r_cause <= ERR_NONE;
            end
            if (w_refuse) begin
                r_err   <= 1'b1;
                r_cause <= ERR_INCOMPLETE;
            end
            if (w_complete) begin
                r_result <= bk_out;
                r_done   <= 1'b1;
                r_loaded <= '0;
            end
            if (w_timeout) begin
                r_err    <= 1'b1;
                r_cause  <= ERR_TIMEOUT;
                r_loaded <= '0;
            end
        end
    end

    assign op1       = r_op[0];
    assign op2       = r_op[1];
    assign op3       = r_op[2];
    assign op4       = r_op[3];
    assign result    = r_result;
    assign loaded    = r_loaded;
    assign done      = r_done;
    assign err       = r_err;
    assign err_cause = r_cause;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_block_sequencer.sv
// Directed bench for block_sequencer with TIMEOUT=8: launch, refusal,
// timeout, rdy/timeout race, held go, reset abort and clr/set priority.
module tb_block_sequencer;
    import block_seq_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   ld_stb = '0;
    logic [W-1:0] ld_data = '0;
    logic         go = 1'b0;
    logic         clr = 1'b0;
    logic [W-1:0] op1, op2, op3, op4;
    logic         bk_go;
    logic         bk_rdy = 1'b0;
    logic [W-1:0] bk_out = '0;
    logic [W-1:0] result;
    logic [3:0]   loaded;
    logic         busy, done, err;
    logic [1:0]   err_cause;
    state_t       dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    block_sequencer #(.W(W), .TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .ld_stb(ld_stb), .ld_data(ld_data), .go(go),
        .clr(clr), .op1(op1), .op2(op2), .op3(op3), .op4(op4), .bk_go(bk_go),
        .bk_rdy(bk_rdy), .bk_out(bk_out), .result(result), .loaded(loaded),
        .busy(busy), .done(done), .err(err), .err_cause(err_cause),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are observed 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if ({op1, op2, op3, op4, result} !== 20'h0) $display("FAIL reset_data: got %h expected 0", {op1, op2, op3, op4, result});
        else n_pass++;
        n_checks++;
        if ({bk_go, busy, done, err, err_cause, loaded} !== 10'h0) $display("FAIL reset_status: got %b expected 0", {bk_go, busy, done, err, err_cause, loaded});
        else n_pass++;
        n_checks++;
        if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
        else n_pass++;
    endtask

    task automatic test_basic();
        int go_pulses = 0;
        ld_stb = 4'b0001; ld_data = 4'd3; tick();
        ld_stb = 4'b0010; ld_data = 4'd5; tick();
        ld_stb = 4'b0100; ld_data = 4'd7; tick();
        ld_stb = 4'b1000; ld_data = 4'd9; tick();
        ld_stb = 4'b0000;
        n_checks++;
        if ({op1, op2, op3, op4, loaded} !== 20'h3579F) $display("FAIL basic_load: got %h expected 3579f", {op1, op2, op3, op4, loaded});
        else n_pass++;
        go = 1'b1;
        tick();
        go_pulses += int'(bk_go);
        go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            go_pulses += int'(bk_go);
        end
        bk_rdy = 1'b1; bk_out = 4'hA;
        tick();
        go_pulses += int'(bk_go);
        bk_rdy = 1'b0;
        n_checks++;
        if (go_pulses !== 1) $display("FAIL basic_bk_go_pulses: got %0d expected 1", go_pulses);
        else n_pass++;
        n_checks++;
        if ({result, done, err, busy, loaded} !== {4'hA, 3'b100, 4'h0}) $display("FAIL basic_result: got %h/%b%b%b/%h expected a/100/0", result, done, err, busy, loaded);
        else n_pass++;
    endtask

    task automatic test_incomplete();
        ld_stb = 4'b0011; ld_data = 4'd6;
        tick();
        ld_stb = 4'b0000;
        n_checks++;
        if ({op1, op2, loaded} !== 12'h663) $display("FAIL multi_strobe: got %h expected 663", {op1, op2, loaded});
        else n_pass++;
        go = 1'b1;
        tick();
        go = 1'b0;
        n_checks++;
        if ({err, err_cause, bk_go, busy} !== 5'b10100) $display("FAIL incomplete_err: got %b expected 10100", {err, err_cause, bk_go, busy});
        else n_pass++;
        tick();
        n_checks++;
        if ({loaded, op1, done, err} !== {4'b0011, 4'd6, 2'b11}) $display("FAIL incomplete_kept: got %h expected 36 with done,err=11", {loaded, op1, done, err});
        else n_pass++;
    endtask

    task automatic test_timeout();
        int n_run = 0;
        // Go edge in the same cycle as the final loads sees the old 0011 mask.
        ld_stb = 4'b1100; ld_data = 4'd8; go = 1'b1;
        tick();
        ld_stb = 4'b0000; go = 1'b0;
        n_checks++;
        if (dbg_state !== ERR || bk_go !== 1'b0 || loaded !== 4'hF || op4 !== 4'd8)
            $display("FAIL go_preload_mask: got state %0d bk_go %b loaded %h op4 %h expected 3 0 f 8", dbg_state, bk_go, loaded, op4);
        else n_pass++;
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        n_checks++;
        if ({bk_go, busy, done, err, err_cause} !== 6'b110000) $display("FAIL launch_clears: got %b expected 110000", {bk_go, busy, done, err, err_cause});
        else n_pass++;
        tick();
        while (busy && !err && n_run < 20) begin
            n_run++;
            tick();
        end
        n_checks++;
        if (n_run !== 8) $display("FAIL timeout_cycles: got %0d expected 8", n_run);
        else n_pass++;
        n_checks++;
        if ({err, busy, err_cause, loaded, done} !== {2'b10, ERR_TIMEOUT, 4'h0, 1'b0}) $display("FAIL timeout_flags: got %b expected 101000000", {err, busy, err_cause, loaded, done});
        else n_pass++;
        tick();
    endtask

    task automatic test_coincident();
        ld_stb = 4'hF; ld_data = 4'd4;
        tick();
        ld_stb = 4'h0; go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) tick();
        bk_rdy = 1'b1; bk_out = 4'd5;
        tick();
        bk_rdy = 1'b0;
        tick();
        n_checks++;
        if ({result, done, err, err_cause, busy} !== {4'd5, 2'b10, ERR_NONE, 1'b0}) $display("FAIL rdy_vs_timeout: got %h/%b expected 5/10000", result, {done, err, err_cause, busy});
        else n_pass++;
    endtask

    task automatic test_hold_go();
        int extra_go = 0;
        ld_stb = 4'hF; ld_data = 4'd2;
        tick();
        ld_stb = 4'h0; go = 1'b1;
        tick();
        ld_stb = 4'b0001; ld_data = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            extra_go += int'(bk_go);
        end
        bk_rdy = 1'b1; bk_out = 4'd3; ld_stb = 4'h0;
        tick();
        bk_rdy = 1'b0;
        n_checks++;
        if (op1 !== 4'd2 || result !== 4'd3) $display("FAIL frozen_operand: got op1 %h result %h expected 2 3", op1, result);
        else n_pass++;
        ld_stb = 4'hF; ld_data = 4'd1;
        tick();
        ld_stb = 4'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            extra_go += int'(bk_go) + int'(busy);
        end
        n_checks++;
        if (extra_go !== 0) $display("FAIL held_go_relaunch: got %0d extra busy/bk_go cycles expected 0", extra_go);
        else n_pass++;
        go = 1'b0;
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        n_checks++;
        if (bk_go !== 1'b1) $display("FAIL second_launch: got bk_go %b expected 1", bk_go);
        else n_pass++;
        tick();
        bk_rdy = 1'b1; bk_out = 4'd7;
        tick();
        bk_rdy = 1'b0;
        n_checks++;
        if (result !== 4'd7 || done !== 1'b1) $display("FAIL second_result: got %h/%b expected 7/1", result, done);
        else n_pass++;
    endtask

    task automatic test_reset_run();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ld_stb = 4'hF; ld_data = 4'd6;
        tick();
        ld_stb = 4'h0; go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; bk_rdy = 1'b1; bk_out = 4'hC;
        tick();
        tick();
        bk_rdy = 1'b0;
        n_checks++;
        if ({result, op1, loaded, done, err, busy, bk_go, err_cause} !== 18'h0) $display("FAIL reset_in_run: got %h expected 0", {result, op1, loaded, done, err, busy, bk_go, err_cause});
        else n_pass++;
    endtask

    task automatic test_clr();
        ld_stb = 4'hF; ld_data = 4'd1;
        tick();
        ld_stb = 4'h0; go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        bk_rdy = 1'b1; bk_out = 4'd9; clr = 1'b1;
        tick();
        bk_rdy = 1'b0; clr = 1'b0;
        n_checks++;
        if (done !== 1'b1 || result !== 4'd9) $display("FAIL clr_vs_set: got done %b result %h expected 1 9", done, result);
        else n_pass++;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++;
        if (done !== 1'b0 || result !== 4'd9) $display("FAIL clr_only: got done %b result %h expected 0 9", done, result);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_incomplete();
        test_timeout();
        test_coincident();
        test_hold_go();
        test_reset_run();
        test_clr();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
